// File: rtl/inst_fetch_bridge.sv
// inst_fetch_bridge
// Builds 32-bit instructions from a byte-wide memory using a valid/ready byte
// handshake. The last fetched word stays in a one-entry buffer, so a repeated
// or stalled fetch of the same word hits with no added latency.
// A miss raises stall_req_o in the same cycle. It stays high until the word is
// buffered and the fetch hits.
// Optional feature: define INST_FETCH_BRIDGE_PREFETCH_EN to add a second,
// sequentially prefetched entry.
module inst_fetch_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [31:0]           inst_o,
  output logic                  valid_o,
  output logic                  stall_req_o,
  output logic                  mem_rd_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [7:0]            mem_data_i,
  input  logic                  mem_rdy_i
);

  localparam int AW = ADDR_WIDTH;
  localparam int WW = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  // Drop a returned byte into its lane of the word being assembled.
  function automatic logic [31:0] place_byte(input logic [31:0] word,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  data);
    logic [31:0] w;
    logic [1:0]  lane;
    w    = word;
    lane = BIG_ENDIAN ? (2'd3 - idx) : idx;
    case (lane)
      2'd0:    w[7:0]   = data;
      2'd1:    w[15:8]  = data;
      2'd2:    w[23:16] = data;
      default: w[31:24] = data;
    endcase
    return w;
  endfunction

  state_e          state_q, state_d;
  logic [WW-1:0]   fill_addr_q, fill_addr_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [31:0]     asm_q, asm_d;
  logic            discard_q, discard_d;
  logic            buf_valid_q, buf_valid_d;
  logic [WW-1:0]   buf_addr_q, buf_addr_d;
  logic [31:0]     buf_data_q, buf_data_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;

  logic            hit_main_s, hit_s, miss_s, redirect_s, abort_s;
  logic [31:0]     hit_data_s;
  logic            unused_s;

`ifdef INST_FETCH_BRIDGE_PREFETCH_EN
  logic            is_pf_q, is_pf_d;
  logic            pf_valid_q, pf_valid_d;
  logic [WW-1:0]   pf_addr_q, pf_addr_d;
  logic [31:0]     pf_data_q, pf_data_d;
  logic            hit_pf_s;
`endif

  // Byte offset bits of the fetch address never take part in matching.
  assign unused_s   = ^addr_i[1:0];

  assign hit_main_s = ce_i & buf_valid_q & (addr_i[AW-1:2] == buf_addr_q);
  assign redirect_s = ce_i & (addr_i[AW-1:2] != fill_addr_q);
  assign miss_s     = ce_i & ~hit_s;

`ifdef INST_FETCH_BRIDGE_PREFETCH_EN
  assign hit_pf_s   = ce_i & pf_valid_q & (addr_i[AW-1:2] == pf_addr_q);
  assign hit_s      = hit_main_s | hit_pf_s;
  assign hit_data_s = hit_main_s ? buf_data_q : pf_data_q;
  // A prefetch is abandoned only by a demand miss elsewhere.
  // A demand fill is abandoned by any redirect.
  assign abort_s    = is_pf_q ? (miss_s & redirect_s) : redirect_s;
`else
  assign hit_s      = hit_main_s;
  assign hit_data_s = buf_data_q;
  assign abort_s    = redirect_s;
`endif

  assign mem_rd_o   = (state_q == S_REQ);
  assign mem_addr_o = mem_addr_q;

  // Hit, miss and stall indication toward the cpu, all in the fetch cycle.
  always_comb begin
    inst_o      = 32'd0;
    valid_o     = 1'b0;
    stall_req_o = 1'b0;
    if (hit_s) begin
      inst_o  = hit_data_s;
      valid_o = 1'b1;
    end else begin
      stall_req_o = miss_s;
    end
  end

  // Fill sequencer: next state, byte assembly and buffer update.
  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    byte_cnt_d  = byte_cnt_q;
    asm_d       = asm_q;
    discard_d   = discard_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    mem_addr_d  = mem_addr_q;
`ifdef INST_FETCH_BRIDGE_PREFETCH_EN
    is_pf_d     = is_pf_q;
    pf_valid_d  = pf_valid_q;
    pf_addr_d   = pf_addr_q;
    pf_data_d   = pf_data_q;
    if (hit_pf_s & ~hit_main_s) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = pf_addr_q;
      buf_data_d  = pf_data_q;
      pf_valid_d  = 1'b0;
    end else begin
      pf_valid_d  = pf_valid_q;
    end
`endif
    case (state_q)
      S_IDLE: begin
        if (miss_s) begin
          fill_addr_d = addr_i[AW-1:2];
          byte_cnt_d  = 2'd0;
          asm_d       = 32'd0;
          discard_d   = 1'b0;
          mem_addr_d  = {addr_i[AW-1:2], 2'b00};
          state_d     = S_REQ;
`ifdef INST_FETCH_BRIDGE_PREFETCH_EN
          is_pf_d     = 1'b0;
`endif
        end
`ifdef INST_FETCH_BRIDGE_PREFETCH_EN
        else if (buf_valid_q & ~pf_valid_q & ~hit_pf_s) begin
          fill_addr_d = buf_addr_q + {{(WW-1){1'b0}}, 1'b1};
          byte_cnt_d  = 2'd0;
          asm_d       = 32'd0;
          discard_d   = 1'b0;
          mem_addr_d  = {buf_addr_q + {{(WW-1){1'b0}}, 1'b1}, 2'b00};
          state_d     = S_REQ;
          is_pf_d     = 1'b1;
        end
`endif
        else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        // The strobe goes out regardless; a redirect only marks the fill dead.
        discard_d = discard_q | abort_s;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        discard_d = discard_q | abort_s;
        if (mem_rdy_i) begin
          asm_d = place_byte(asm_q, byte_cnt_q, mem_data_i);
          if (discard_q | abort_s) begin
            discard_d = 1'b0;
            state_d   = S_IDLE;
          end else if (byte_cnt_q == 2'd3) begin
            state_d = S_IDLE;
`ifdef INST_FETCH_BRIDGE_PREFETCH_EN
            if (is_pf_q) begin
              pf_valid_d = 1'b1;
              pf_addr_d  = fill_addr_q;
              pf_data_d  = asm_d;
            end else begin
              buf_valid_d = 1'b1;
              buf_addr_d  = fill_addr_q;
              buf_data_d  = asm_d;
            end
`else
            buf_valid_d = 1'b1;
            buf_addr_d  = fill_addr_q;
            buf_data_d  = asm_d;
`endif
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            mem_addr_d = {fill_addr_q, byte_cnt_d};
            state_d    = S_REQ;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and buffer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      fill_addr_q <= '0;
      byte_cnt_q  <= 2'd0;
      asm_q       <= 32'd0;
      discard_q   <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= 32'd0;
      mem_addr_q  <= '0;
`ifdef INST_FETCH_BRIDGE_PREFETCH_EN
      is_pf_q     <= 1'b0;
      pf_valid_q  <= 1'b0;
      pf_addr_q   <= '0;
      pf_data_q   <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      byte_cnt_q  <= byte_cnt_d;
      asm_q       <= asm_d;
      discard_q   <= discard_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      mem_addr_q  <= mem_addr_d;
`ifdef INST_FETCH_BRIDGE_PREFETCH_EN
      is_pf_q     <= is_pf_d;
      pf_valid_q  <= pf_valid_d;
      pf_addr_q   <= pf_addr_d;
      pf_data_q   <= pf_data_d;
`endif
    end
  end

endmodule
